// File: rtl/fft_pkg.sv
// Shared constants and FSM encoding for the radix-2 DIT FFT address sequencer.
package fft_pkg;

  localparam int N_LOG2_DEF = 3;
  localparam int N_DEF      = 1 << N_LOG2_DEF;
  localparam int N_HALF_DEF = N_DEF / 2;
  localparam int ADDR_W_DEF = N_LOG2_DEF;
  localparam int TW_W_DEF   = N_LOG2_DEF - 1;
  localparam int STG_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/wrap_cnt.sv
// Wrap-around counter: advances on i_en, returns to 0 after MAX; o_term flags MAX combinationally.
// o_nxt exposes the value the counter will hold after this edge so callers can register derived data.
module wrap_cnt #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_nxt,
  output logic         o_term
);

  logic [W-1:0] cnt_q, cnt_d;

  assign o_term = (cnt_q == W'(MAX));
  assign o_nxt  = cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = o_term ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fft_bfly_addr_gen.sv
// In-place radix-2 DIT FFT address sequencer: one (A, B, twiddle, stage) beat per transfer, first beat 1 cycle after start.
// Beat outputs are registered and hold while o_valid && !i_ready; counters only advance on a transfer.
module fft_bfly_addr_gen
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int ADDR_W = N_LOG2,
  parameter int TW_W   = N_LOG2 - 1,
  parameter int STG_W  = STG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr_a,
  output logic [ADDR_W-1:0] o_addr_b,
  output logic [TW_W-1:0]   o_twiddle,
  output logic [STG_W-1:0]  o_stage,
  output logic              o_stage_last,
  output logic              o_busy,
  output logic              o_done
);

  localparam int N_HALF = 1 << (N_LOG2 - 1);

  state_t state_q, state_d;
  logic   clr;
  logic   xfer;

  logic [TW_W-1:0]  j_d;
  logic             j_term;
  logic [STG_W-1:0] s_d;
  logic             s_term;

  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [TW_W-1:0]   twiddle_q, twiddle_d;
  logic [STG_W-1:0]  stage_q, stage_d;
  logic              stage_last_q, stage_last_d;

  logic [ADDR_W-1:0] j_ext, half, pos, grp, addr_a;
  logic [STG_W-1:0]  tw_sh;

  // o_valid is exactly "in RUN", so a transfer needs only the state and i_ready.
  assign xfer = (state_q == RUN) && i_ready;

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = RUN;
          clr     = 1'b1;
        end
      end
      RUN: begin
        if (xfer && j_term && s_term) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  wrap_cnt #(
    .W   (TW_W),
    .MAX (N_HALF - 1)
  ) u_bfly_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (clr),
    .i_en   (xfer),
    .o_nxt  (j_d),
    .o_term (j_term)
  );

  wrap_cnt #(
    .W   (STG_W),
    .MAX (N_LOG2 - 1)
  ) u_stage_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (clr),
    .i_en   (xfer && j_term),
    .o_nxt  (s_d),
    .o_term (s_term)
  );

  // Beat fields are computed from the counters' next values so they register alongside them.
  always_comb begin
    j_ext    = ADDR_W'(j_d);
    half     = ADDR_W'(1) << s_d;
    pos      = j_ext & (half - ADDR_W'(1));
    grp      = j_ext >> s_d;
    addr_a   = ((grp << s_d) << 1) | pos;
    tw_sh    = STG_W'(N_LOG2 - 1) - s_d;

    addr_a_d     = '0;
    addr_b_d     = '0;
    twiddle_d    = '0;
    stage_d      = '0;
    stage_last_d = 1'b0;
    if (state_d == RUN) begin
      addr_a_d     = addr_a;
      addr_b_d     = addr_a + half;
      twiddle_d    = TW_W'(pos << tw_sh);
      stage_d      = s_d;
      stage_last_d = (j_d == TW_W'(N_HALF - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      twiddle_q    <= '0;
      stage_q      <= '0;
      stage_last_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_a_q     <= addr_a_d;
      addr_b_q     <= addr_b_d;
      twiddle_q    <= twiddle_d;
      stage_q      <= stage_d;
      stage_last_q <= stage_last_d;
    end
  end

  assign o_valid      = (state_q == RUN);
  assign o_busy       = (state_q == RUN);
  assign o_done       = (state_q == DONE);
  assign o_addr_a     = addr_a_q;
  assign o_addr_b     = addr_b_q;
  assign o_twiddle    = twiddle_q;
  assign o_stage      = stage_q;
  assign o_stage_last = stage_last_q;

endmodule

// File: tb/tb_fft_bfly_addr_gen.sv
// Bench for fft_bfly_addr_gen: 8-point and 16-point instances, scoreboard queues checked by monitors.
module tb_fft_bfly_addr_gen;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] tw;
    logic [3:0] stg;
    logic       last;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // 8-point instance
  logic       i_start = 1'b0;
  logic       i_ready = 1'b1;
  logic       o_valid, o_stage_last, o_busy, o_done;
  logic [2:0] o_addr_a, o_addr_b;
  logic [1:0] o_twiddle;
  logic [3:0] o_stage;

  // 16-point instance
  logic       i_start2 = 1'b0;
  logic       i_ready2 = 1'b1;
  logic       o2_valid, o2_stage_last, o2_busy, o2_done;
  logic [3:0] o2_addr_a, o2_addr_b;
  logic [2:0] o2_twiddle;
  logic [3:0] o2_stage;

  fft_bfly_addr_gen dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_ready(i_ready),
    .o_valid(o_valid), .o_addr_a(o_addr_a), .o_addr_b(o_addr_b),
    .o_twiddle(o_twiddle), .o_stage(o_stage), .o_stage_last(o_stage_last),
    .o_busy(o_busy), .o_done(o_done)
  );

  fft_bfly_addr_gen #(.N_LOG2(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .i_start(i_start2), .i_ready(i_ready2),
    .o_valid(o2_valid), .o_addr_a(o2_addr_a), .o_addr_b(o2_addr_b),
    .o_twiddle(o2_twiddle), .o_stage(o2_stage), .o_stage_last(o2_stage_last),
    .o_busy(o2_busy), .o_done(o2_done)
  );

  // Hand-computed 8-point sequence (a, b, twiddle)
  logic [3:0] tab_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  logic [3:0] tab_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  logic [2:0] tab_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  beat_t sb1[$];
  beat_t sb2[$];
  int    done1[$];
  int    done2[$];
  int    seen1 = 0;
  int    seen2 = 0;
  beat_t act1, act2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      act1 = {1'b0, o_addr_a, 1'b0, o_addr_b, 1'b0, o_twiddle, o_stage, o_stage_last};
      if (o_valid) begin
        chk("busy_with_valid", {31'd0, o_busy}, 32'd1);
        if (sb1.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat got %h with no beat expected", act1);
        end else if (i_ready) begin
          chk("beat8", act1, sb1.pop_front());
          seen1++;
        end else begin
          chk("stall_hold8", act1, sb1[0]);
        end
      end
      if (o_done) begin
        chk("done_valid_low", {31'd0, o_valid}, 32'd0);
        chk("done_busy_low", {31'd0, o_busy}, 32'd0);
        if (done1.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          chk("done_cycle8", cyc, done1.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      act2 = {o2_addr_a, o2_addr_b, o2_twiddle, o2_stage, o2_stage_last};
      if (o2_valid && i_ready2) begin
        if (sb2.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat16 got %h with no beat expected", act2);
        end else begin
          chk("beat16", act2, sb2.pop_front());
          seen2++;
        end
      end
      if (o2_done) begin
        if (done2.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done16 got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          chk("done_cycle16", cyc, done2.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start8(input int stalls);
    beat_t e;
    for (int i = 0; i < 12; i++) begin
      e.a = tab_a[i]; e.b = tab_b[i]; e.tw = tab_tw[i];
      e.stg = 4'(i / 4); e.last = (i % 4 == 3);
      sb1.push_back(e);
    end
    done1.push_back(cyc + 13 + stalls);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic start16();
    beat_t e;
    int half;
    for (int s = 0; s < 4; s++) begin
      half = 1 << s;
      for (int g = 0; g < 8 / half; g++) begin
        for (int p = 0; p < half; p++) begin
          e.a = 4'(g * 2 * half + p); e.b = 4'(g * 2 * half + p + half);
          e.tw = 3'(p * (8 / half)); e.stg = 4'(s);
          e.last = (g == 8 / half - 1) && (p == half - 1);
          sb2.push_back(e);
        end
      end
    end
    done2.push_back(cyc + 33);
    i_start2 = 1'b1;
    tick();
    i_start2 = 1'b0;
  endtask

  task automatic wait_seen(input int target);
    int k;
    for (k = 0; k < 200; k++) begin
      if (seen1 >= target) break;
      tick();
    end
    if (k == 200) begin
      checks++; errors++;
      $display("FAIL wait_beat got %0d beats expected %0d", seen1, target);
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      if (sb1.size() == 0 && done1.size() == 0 && sb2.size() == 0 && done2.size() == 0) break;
      tick();
    end
    if (k == 300) begin
      checks++; errors++;
      $display("FAIL %s_timeout got %0d beats left expected 0", name, sb1.size() + sb2.size());
    end
    repeat (3) tick();
    chk({name, "_idle_valid"}, {30'd0, o_valid, o2_valid}, 32'd0);
    chk({name, "_idle_busy"}, {30'd0, o_busy, o2_busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // Reset held with start toggling: every output stays 0
    for (int i = 0; i < 4; i++) begin
      i_start = ~i_start;
      tick();
      chk("reset_out8", {o_valid, o_addr_a, o_addr_b, o_twiddle, o_stage, o_stage_last, o_busy, o_done}, 32'd0);
      chk("reset_out16", {o2_valid, o2_addr_a, o2_addr_b, o2_twiddle, o2_stage, o2_stage_last, o2_busy, o2_done}, 32'd0);
    end
    i_start = 1'b0;
    rst_n   = 1'b1;
    repeat (4) begin
      tick();
      chk("idle_no_start", {30'd0, o_valid, o_busy}, 32'd0);
    end

    // Full 8-point run, no stalls
    start8(0);
    wait_idle("full");

    // Backpressure at beat (1,3,2) for 3 cycles
    base = seen1;
    start8(3);
    wait_seen(base + 5);
    i_ready = 1'b0;
    repeat (3) tick();
    i_ready = 1'b1;
    wait_idle("stall");

    // Start while busy, on the last beat, and during the done cycle
    base = seen1;
    start8(0);
    wait_seen(base + 4);
    i_start = 1'b1; tick(); i_start = 1'b0;
    wait_seen(base + 11);
    i_start = 1'b1; tick(); i_start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (o_done) break;
      tick();
    end
    i_start = 1'b1; tick(); i_start = 1'b0;
    wait_idle("restart");

    // Asynchronous reset at beat 7
    base = seen1;
    start8(0);
    wait_seen(base + 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset", {o_valid, o_addr_a, o_addr_b, o_twiddle, o_stage, o_stage_last, o_busy, o_done}, 32'd0);
    sb1.delete();
    done1.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    start8(0);
    wait_idle("post_reset");

    // 16-point regression
    start16();
    wait_idle("n16");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
